// File: rtl/spi_master.sv
// Single-byte SPI mode-0 master, MSB first, sclk derived from clk by CLK_DIV.
// Optional SPI_LOOPBACK_EN adds a loopback input that feeds mosi back into the rx path.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
`ifdef SPI_LOOPBACK_EN
  ,
  input  logic              loopback
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              half_tick;
  logic              rx_bit;

  assign half_tick = (div_cnt == DIV_LAST);

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = loopback ? mosi : miso;
`else
  assign rx_bit = miso;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      dout    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sh   <= din;
            rx_sh   <= '0;
            cs      <= 1'b0;
            mosi    <= din[DATA_W-1];
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (half_tick) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            rx_sh   <= {rx_sh[DATA_W-2:0], rx_bit};
            bit_cnt <= bit_cnt + 1'b1;
            state   <= XFER;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        XFER: begin
          if (half_tick) begin
            div_cnt <= '0;
            if (sclk) begin
              // Falling edge: present the next bit, or leave mosi alone after the last one
              sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= HOLD;
              end else begin
                mosi  <= tx_sh[DATA_W-2];
                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
              end
            end else begin
              sclk    <= 1'b1;
              rx_sh   <= {rx_sh[DATA_W-2:0], rx_bit};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (half_tick) begin
            div_cnt <= '0;
            cs      <= 1'b1;
            mosi    <= 1'b0;
            dout    <= rx_sh;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table of full frames plus reset, ignored-start,
// back-to-back and CLK_DIV=2 sequences; loopback cases when SPI_LOOPBACK_EN is defined.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       busy, done, sclk, cs, mosi;
  logic       miso = 1'b0;
  logic       loopback = 1'b0;

  logic       start_b = 1'b0;
  logic [7:0] din_b = 8'h00;
  logic [7:0] dout_b;
  logic       busy_b, done_b, sclk_b, cs_b, mosi_b;
  logic       miso_b = 1'b1;

  int checks = 0;
  int failures = 0;

  // slave model state
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] sl_sh = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  int         sclk_pulses = 0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(4), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .din(din), .dout(dout),
    .busy(busy), .done(done), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
`ifdef SPI_LOOPBACK_EN
    , .loopback(loopback)
`endif
  );

  spi_master #(.CLK_DIV(2), .DATA_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .din(din_b), .dout(dout_b),
    .busy(busy_b), .done(done_b), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b)
`ifdef SPI_LOOPBACK_EN
    , .loopback(1'b0)
`endif
  );

  // Mode-0 slave: first bit valid at cs fall, shifts on sclk fall, captures mosi on sclk rise
  always @(negedge cs) begin
    sl_sh = sl_tx;
    miso = sl_sh[7];
    mosi_cap = 8'h00;
    sclk_pulses = 0;
  end
  always @(negedge sclk) begin
    if (!cs) begin
      sl_sh = {sl_sh[6:0], 1'b0};
      miso = sl_sh[7];
    end
  end
  always @(posedge sclk) begin
    if (!cs) begin
      mosi_cap = {mosi_cap[6:0], mosi};
      sclk_pulses++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One full frame on the CLK_DIV=4 instance; inj>0 pulses start with din=FF at that cycle
  task automatic run_frame(input string nm, input logic [7:0] d, input logic [7:0] s,
                           input logic [7:0] exp_d, input logic [7:0] exp_m, input int inj);
    int done_at, done_cnt, cs_low;
    logic busy_at_done;
    done_at = -1; done_cnt = 0; cs_low = 0; busy_at_done = 1'b1;
    sl_tx = s;
    @(negedge clk);
    start = 1'b1; din = d;
    @(posedge clk); #1;
    start = 1'b0; din = ~d;
    chk({nm, "_busy_e0"}, 32'(busy), 32'd1);
    if (!cs) cs_low++;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk); #1;
      if (k == inj) begin
        start = 1'b1; din = 8'hFF;
      end else if (k == inj + 1) begin
        start = 1'b0;
      end
      if (!cs) cs_low++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          busy_at_done = busy;
        end
      end
    end
    chk({nm, "_done_cycle"}, 32'(done_at), 32'd68);
    chk({nm, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({nm, "_cs_low"}, 32'(cs_low), 32'd68);
    chk({nm, "_sclk_pulses"}, 32'(sclk_pulses), 32'd8);
    chk({nm, "_mosi"}, 32'(mosi_cap), 32'(exp_m));
    chk({nm, "_dout"}, 32'(dout), 32'(exp_d));
    chk({nm, "_busy_done"}, 32'(busy_at_done), 32'd0);
  endtask

  typedef struct {
    string      nm;
    logic [7:0] d;
    logic [7:0] s;
    logic [7:0] exp_dout;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int d1, d2, cs_hi, db;
    logic [7:0] r1, cap1, cap2;

    tbl[0] = '{"a5_3c", 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    tbl[1] = '{"00_ff", 8'h00, 8'hFF, 8'hFF, 8'h00};
    tbl[2] = '{"ff_00", 8'hFF, 8'h00, 8'h00, 8'hFF};
    tbl[3] = '{"81_7e", 8'h81, 8'h7E, 8'h7E, 8'h81};
    tbl[4] = '{"5a_c3", 8'h5A, 8'hC3, 8'hC3, 8'h5A};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].nm, tbl[i].d, tbl[i].s, tbl[i].exp_dout, tbl[i].exp_mosi, 0);

    // Asynchronous reset in the middle of a frame
    sl_tx = 8'h3C;
    @(negedge clk);
    start = 1'b1; din = 8'hA5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_sclk_before", 32'(sclk), 32'd1);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_cs", 32'(cs), 32'd1);
    chk("mid_rst_sclk", 32'(sclk), 32'd0);
    chk("mid_rst_mosi", 32'(mosi), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_frame("after_rst", 8'hA5, 8'h3C, 8'h3C, 8'hA5, 0);

    // start during a frame is ignored
    run_frame("ignored_start", 8'h81, 8'h66, 8'h66, 8'h81, 20);

    // start held high: two back-to-back frames
    d1 = -1; d2 = -1; cs_hi = 0; r1 = 8'h00; cap1 = 8'h00; cap2 = 8'h00;
    sl_tx = 8'hC3;
    @(negedge clk);
    start = 1'b1; din = 8'h12;
    @(posedge clk); #1;
    din = 8'h34;
    sl_tx = 8'h5A;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done && d1 < 0) begin
        d1 = k; r1 = dout; cap1 = mosi_cap;
      end else if (done && d2 < 0) begin
        d2 = k; cap2 = mosi_cap;
      end
      if (d1 > 0 && d2 < 0 && cs) cs_hi++;
      if (d1 > 0 && k == d1 + 1) start = 1'b0;
    end
    start = 1'b0;
    chk("b2b_done1", 32'(d1), 32'd68);
    chk("b2b_dout1", 32'(r1), 32'hC3);
    chk("b2b_mosi1", 32'(cap1), 32'h12);
    chk("b2b_cs_gap", 32'(cs_hi), 32'd1);
    chk("b2b_done2", 32'(d2), 32'd137);
    chk("b2b_mosi2", 32'(cap2), 32'h34);
    chk("b2b_dout2", 32'(dout), 32'h5A);

    // CLK_DIV=2 instance, miso tied high
    db = -1;
    @(negedge clk);
    start_b = 1'b1; din_b = 8'h00;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (done_b && db < 0) db = k;
    end
    chk("div2_done_cycle", 32'(db), 32'd34);
    chk("div2_dout", 32'(dout_b), 32'hFF);

`ifdef SPI_LOOPBACK_EN
    loopback = 1'b1;
    run_frame("loop_on", 8'h5A, 8'h00, 8'h5A, 8'h5A, 0);
    loopback = 1'b0;
    run_frame("loop_off", 8'h5A, 8'h00, 8'h00, 8'h5A, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
